ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard: 0xED set-LEDs, 0xFF reset, 0xF4 enable, and similar.
- It is the outbound counterpart of the scancode receive/ASCII buffer path, which consumes the keyboard's 0xFA ACK and 0xAA BAT replies.
- It drives the open-drain PS/2 clock and data lines through active-high pull-low enables.
- It reports completion, device ack and error to the command sequencer.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_line_sync.sv | 27 ++
 rtl/ps2_host_tx.sv | 95 +++++++++
 tb/tb_ps2_host_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 command/response codes and host-transmit state encoding
package ps2_pkg;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT     = 8'hAA;
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t ST_IDLE      = 3'd0;
  localparam tx_state_t ST_INHIBIT   = 3'd1;
  localparam tx_state_t ST_REQ       = 3'd2;
  localparam tx_state_t ST_DATA      = 3'd3;
  localparam tx_state_t ST_ACK       = 3'd4;
  localparam tx_state_t ST_WAIT_IDLE = 3'd5;
  localparam tx_state_t ST_FINISH    = 3'd6;
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 lines plus clock falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fe
);
  logic [1:0] clk_ff, data_ff;
  logic clk_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_in};
      data_ff  <= {data_ff[0], data_in};
      clk_prev <= clk_ff[1];
    end
  end
  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];
  assign fe     = clk_prev & ~clk_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ack check and timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);
  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int CW = $clog2(TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
  tx_state_t state;
  logic [7:0] shreg;
  logic [3:0] fe_cnt;
  logic [CW-1:0] inh_cnt, to_cnt;
  logic parity, err, data_oe_r, clk_s, data_s, fe, timing;
  ps2_line_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .clk_in (ps2_clk_in),
    .data_in(ps2_data_in),
    .clk_s  (clk_s),
    .data_s (data_s),
    .fe     (fe)
  );
  assign timing = state != ST_IDLE && state != ST_FINISH;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      parity    <= 1'b0;
      fe_cnt    <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
      data_oe_r <= 1'b0;
    end else if (timing && to_cnt == TO_LAST) begin
      state     <= ST_FINISH;
      err       <= 1'b1;
      data_oe_r <= 1'b0;
    end else begin
      if (timing) to_cnt <= to_cnt + 1'b1;
      case (state)
        ST_IDLE: if (tx_start) begin
          shreg   <= tx_data;
          parity  <= ~^tx_data;
          fe_cnt  <= '0;
          inh_cnt <= '0;
          to_cnt  <= '0;
          err     <= 1'b0;
          state   <= ST_INHIBIT;
        end
        ST_INHIBIT: if (inh_cnt == INH_LAST) begin
          data_oe_r <= 1'b1;
          state     <= ST_REQ;
        end else inh_cnt <= inh_cnt + 1'b1;
        // fe_cnt holds edges already seen: 0..7 data, 8 parity, 9 stop
        ST_REQ, ST_DATA: if (fe) begin
          fe_cnt    <= fe_cnt + 1'b1;
          shreg     <= shreg >> 1;
          data_oe_r <= fe_cnt < 4'd8 ? ~shreg[0] : fe_cnt == 4'd8 ? ~parity : 1'b0;
          state     <= fe_cnt == 4'd9 ? ST_ACK : ST_DATA;
        end
        ST_ACK: if (fe) begin
          err   <= data_s;
          state <= data_s ? ST_FINISH : ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: if (clk_s & data_s) state <= ST_FINISH;
        ST_FINISH: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign ps2_clk_oe  = state == ST_INHIBIT;
  assign ps2_data_oe = data_oe_r;
  assign tx_busy     = state != ST_IDLE;
  assign rx_inhibit  = tx_busy;
  assign tx_done     = state == ST_FINISH;
  assign tx_error    = tx_done & err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench driving ps2_host_tx against an open-drain PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH_CYC = 100;
  localparam int TO_CYC  = 15000;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_start = 1'b0, dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error, rx_inhibit;
  logic clk_line, data_line;
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, lone_err = 0, both_oe = 0, inh_mis = 0;
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);
  always #5 clk = ~clk;
  ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(100), .TIMEOUT_US(15000)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit)
  );
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_error && !tx_done) lone_err++;
      if (ps2_clk_oe && ps2_data_oe) both_oe++;
      if (rx_inhibit !== tx_busy) inh_mis++;
    end
  end
  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask
  task automatic check_inhibit(input string tag);
    int n, g;
    n = 0;
    g = 0;
    while (!ps2_clk_oe && g < 10) begin @(negedge clk); g++; end
    while (ps2_clk_oe && n < 1000) begin n++; @(negedge clk); end
    vectors++;
    if (n != INH_CYC) begin miscompares++; $display("FAIL %s inhibit_len got %0d want %0d", tag, n, INH_CYC); end
    vectors++;
    if (ps2_data_oe !== 1'b1) begin miscompares++; $display("FAIL %s start_bit data_oe got %b want 1", tag, ps2_data_oe); end
  endtask
  // device clocks n_fe bits at 12.5 kHz, sampling the data line on each rising edge
  task automatic dev_clock(input int n_fe, input bit ack, output logic [9:0] bits);
    int g;
    g = 0;
    bits = '0;
    while (ps2_clk_oe && g < 1000) begin @(negedge clk); g++; end
    repeat (40) @(negedge clk);
    for (int i = 1; i <= n_fe; i++) begin
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      if (i <= 10) bits[i-1] = data_line;
      if (i == 10) dev_data_low = ack;
      dev_clk_low = 1'b0;
      repeat (40) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (tx_busy && g < 2000) begin @(negedge clk); g++; end
    vectors++;
    if (tx_busy) begin miscompares++; $display("FAIL %s busy_stuck got 1 want 0", tag); end
    #1;
  endtask
  task automatic do_transfer(input logic [7:0] d, input bit ack, input logic [9:0] exp_bits,
                             input bit started, input string tag);
    int d0, e0;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    if (!started) start_tx(d);
    check_inhibit(tag);
    dev_clock(11, ack, bits);
    wait_idle(tag);
    vectors++;
    if (bits !== exp_bits) begin miscompares++; $display("FAIL %s line_bits got %h want %h", tag, bits, exp_bits); end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt - d0); end
    vectors++;
    if (err_cnt - e0 != (ack ? 0 : 1)) begin miscompares++; $display("FAIL %s error_pulses got %0d want %0d", tag, err_cnt - e0, ack ? 0 : 1); end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin miscompares++; $display("FAIL %s lines_released got %b want 00", tag, {ps2_clk_oe, ps2_data_oe}); end
  endtask
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error, rx_inhibit} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 000000", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error, rx_inhibit});
    end
  endtask
  task automatic test_set_led();
    do_transfer(CMD_SET_LED, 1'b1, 10'h3ED, 1'b0, "set_led");
  endtask
  task automatic test_byte07();
    do_transfer(8'h07, 1'b1, 10'h207, 1'b0, "byte07");
  endtask
  task automatic test_back_to_back();
    tx_data = CMD_ENABLE;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    vectors++;
    if ({tx_busy, ps2_clk_oe} !== 2'b11) begin miscompares++; $display("FAIL b2b_accept busy/clk_oe got %b want 11", {tx_busy, ps2_clk_oe}); end
    do_transfer(CMD_ENABLE, 1'b1, 10'h2F4, 1'b1, "b2b");
  endtask
  task automatic test_timeout();
    int n;
    n = 0;
    start_tx(CMD_ECHO);
    vectors++;
    if (ps2_clk_oe !== 1'b1) begin miscompares++; $display("FAIL timeout_enter clk_oe got %b want 1", ps2_clk_oe); end
    while (!tx_done && n < 20000) begin @(negedge clk); n++; end
    vectors++;
    if (n != TO_CYC) begin miscompares++; $display("FAIL timeout_latency got %0d want %0d", n, TO_CYC); end
    vectors++;
    if ({tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 4'b1100) begin
      miscompares++;
      $display("FAIL timeout_outputs done/err/clk_oe/data_oe got %b want 1100", {tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
    end
    wait_idle("timeout");
  endtask
  task automatic test_missing_ack();
    do_transfer(CMD_ENABLE, 1'b0, 10'h2F4, 1'b0, "nack");
  endtask
  task automatic test_busy_ignored();
    int d0;
    logic [9:0] bits;
    d0 = done_cnt;
    start_tx(CMD_SET_LED);
    repeat (10) @(negedge clk);
    tx_data = CMD_ENABLE;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data = 8'h00;
    vectors++;
    if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL busy_flag got %b want 1", tx_busy); end
    dev_clock(11, 1'b1, bits);
    wait_idle("busy_ign");
    vectors++;
    if (bits !== 10'h3ED) begin miscompares++; $display("FAIL busy_ign line_bits got %h want 3ed", bits); end
    repeat (300) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt - d0 != 1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ign done_pulses got %0d busy %b want 1 busy 0", done_cnt - d0, tx_busy);
    end
  endtask
  task automatic test_reset_mid();
    int d0, e0;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h07);
    check_inhibit("rst_mid");
    dev_clock(4, 1'b1, bits);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (ps2_data_oe !== 1'b1) begin miscompares++; $display("FAIL rst_mid bit4 data_oe got %b want 1", ps2_data_oe); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid clk_oe/data_oe/busy got %b want 000", {ps2_clk_oe, ps2_data_oe, tx_busy});
    end
    rst = 1'b0;
    dev_clk_low = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt != d0 || err_cnt != e0) begin
      miscompares++;
      $display("FAIL rst_mid spurious done got %0d err got %0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    do_transfer(CMD_RESET, 1'b1, 10'h3FF, 1'b0, "post_rst");
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_set_led();
    test_byte07();
    test_back_to_back();
    test_timeout();
    test_missing_ack();
    test_busy_ignored();
    test_reset_mid();
    #1;
    vectors++;
    if (lone_err != 0) begin miscompares++; $display("FAIL error_without_done got %0d want 0", lone_err); end
    vectors++;
    if (both_oe != 0) begin miscompares++; $display("FAIL both_lines_driven got %0d want 0", both_oe); end
    vectors++;
    if (inh_mis != 0) begin miscompares++; $display("FAIL rx_inhibit_vs_busy got %0d want 0", inh_mis); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
